counter_mod: RTL and testbench
==============================

COUNTER_MOD -- requirements
Module: counter_mod

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits; SHALL be 1 to 32.
REQ-002 Parameter MAX, default 2**WIDTH-1, terminal (highest) count; SHALL be 1 to 2**WIDTH-1.
REQ-003 Parameter MODE, default 0, terminal behaviour: 0 = wrap, 1 = saturate, 2 = one-shot.
REQ-004 Parameter INIT, default 0, reset value of O; SHALL be at most MAX.
REQ-005 CLK  in  1  sole clock; all state updates on rising edge.
REQ-006 RESETN  in  1  synchronous, active-low reset, sampled on CLK rising edge.
REQ-007 CE  in  1  count enable.
REQ-008 UP  in  1  direction: 1 = increment, 0 = decrement; sampled only when counting.
REQ-009 LOAD  in  1  synchronous load of D.
REQ-010 D  in  WIDTH  load value.
REQ-011 O  out  WIDTH  registered count.
REQ-012 COUT  out  1  combinational terminal-count strobe.
REQ-013 DONE  out  1  registered one-shot completion flag; constant 0 when MODE is not 2.

Function
REQ-014 Priority per edge SHALL be: RESETN low, then LOAD, then CE, then hold.
REQ-015 LOAD high SHALL set O to min(D, MAX) next cycle, independent of CE and UP, and SHALL clear DONE.
REQ-016 With CE high and LOAD low, O SHALL step by exactly 1 per cycle in the UP direction; CE low SHALL hold O.
REQ-017 "At terminal" SHALL mean O == MAX with UP=1, or O == 0 with UP=0.
REQ-018 MODE 0 at terminal: up step from MAX SHALL give 0; down step from 0 SHALL give MAX (modulo MAX+1).
REQ-019 MODE 1 at terminal: O SHALL hold its value; stepping away from the terminal SHALL count normally.
REQ-020 MODE 2 SHALL be a two-state FSM, RUN and DONE; RUN counts as MODE 1; a counting step at terminal SHALL enter DONE (DONE=1); in DONE, O and DONE SHALL hold regardless of CE or UP until LOAD or reset returns the FSM to RUN.
REQ-021 COUT SHALL equal CE AND NOT LOAD AND at-terminal AND (MODE != 2 OR state == RUN); no reset gating beyond O's value.
REQ-022 All arithmetic SHALL be WIDTH bits with no intermediate overflow; for MAX < 2**WIDTH-1, O SHALL never exceed MAX.
REQ-023 A direction change (UP toggling) while CE is high SHALL take effect on the same edge, with no dead cycle.
REQ-024 The design SHALL contain no latches and no combinational path from D to O.

Reset
REQ-025 RESETN low at a rising edge SHALL set O = INIT, DONE = 0, FSM = RUN, overriding LOAD and CE.
REQ-026 Reset asserted mid-count or in DONE SHALL take effect on the next edge with no residual state; counting resumes on the first edge with RESETN high.
REQ-027 Before the first reset edge, outputs are unspecified; the bench SHALL check only after reset.

Verification
REQ-028 Defaults (WIDTH 4, MAX 15, MODE 0), CE=1, UP=1, 17 edges after reset -> O runs 0..15 then 0, then 1; COUT=1 only while O=15.
REQ-029 WIDTH 4, MAX 9, MODE 0, UP=0 from reset -> O: 0, 9, 8, ...; COUT=1 while O=0; O never exceeds 9.
REQ-030 MODE 1, MAX 5, count up 8 edges -> O holds at 5 with COUT=1; UP=0 -> O=4 on the next edge.
REQ-031 MODE 2, MAX 3 -> DONE=1 on the edge after O=3; CE toggling keeps O=3; LOAD with D=1 -> O=1, DONE=0, counting resumes.
REQ-032 LOAD=1 with D=14, MAX=9, CE=1 -> O=9 (clamped) and COUT=0 during the load cycle.
REQ-033 RESETN=0 with LOAD=1, CE=1, INIT=2 -> O=2, DONE=0; RESETN released -> first step gives O=3.

Source files
------------

// File: rtl/counter_mod.sv
// counter_mod: up/down counter with a programmable terminal count and a
// choice of terminal behaviour (wrap, saturate, or one-shot), a synchronous
// clamped load, a combinational terminal-count strobe and a registered
// one-shot completion flag.
module counter_mod #(
    parameter int unsigned      WIDTH = 4,
    parameter longint unsigned  MAX   = (64'd1 << WIDTH) - 64'd1,
    parameter int unsigned      MODE  = 0,
    parameter longint unsigned  INIT  = 64'd0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ce,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] o,
    output logic             cout,
    output logic             done
);

    localparam int unsigned MODE_WRAP     = 0;
    localparam int unsigned MODE_ONE_SHOT = 2;

    localparam logic [WIDTH-1:0] MAX_W  = MAX[WIDTH-1:0];
    localparam logic [WIDTH-1:0] INIT_W = INIT[WIDTH-1:0];

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] o_q;
    logic             done_q;
    logic             at_term;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] load_val;

    // Terminal is direction dependent: top of range going up, zero going down.
    assign at_term = up ? (o_q == MAX_W) : (o_q == '0);

    // Loads are clamped so the count never leaves 0..MAX.
    assign load_val = (d > MAX_W) ? MAX_W : d;

    // Next count for a single counting step, including the terminal rule.
    always_comb begin
        // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
        step_val = o_q;
        if (at_term) begin
            if (MODE == MODE_WRAP) begin
                step_val = up ? '0 : MAX_W;
            end
        end else begin
            // Away from terminal, +1/-1 cannot overflow WIDTH bits.
            step_val = up ? o_q + 1'b1 : o_q - 1'b1;
        end
    end

    // Count register and one-shot FSM: reset, then load, then count, then hold.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!resetn) begin
            o_q    <= INIT_W;
            state  <= ST_RUN;
            done_q <= 1'b0;
        end else if (load) begin
            o_q    <= load_val;
            state  <= ST_RUN;
            done_q <= 1'b0;
        end else if (ce) begin
            if (MODE == MODE_ONE_SHOT && state == ST_DONE) begin
                o_q <= o_q;
            end else begin
                o_q <= step_val;
                if (MODE == MODE_ONE_SHOT && at_term) begin
                    state  <= ST_DONE;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign o    = o_q;
    assign done = (MODE == MODE_ONE_SHOT) ? done_q : 1'b0;
    assign cout = ce & ~load & at_term &
                  ((MODE != MODE_ONE_SHOT) || (state == ST_RUN));

endmodule

// File: tb/tb_counter_mod.sv
// Bench for counter_mod: five instances with different parameter sets,
// directed scenarios followed by randomized traffic, all compared against
// an arithmetic reference model of the counting rules.
module tb_counter_mod;

    localparam int N = 5;
    localparam int P_MAX  [N] = '{15, 9, 5, 3, 20};
    localparam int P_MODE [N] = '{0, 0, 1, 2, 2};
    localparam int P_INIT [N] = '{0, 0, 0, 0, 2};
    localparam int P_W    [N] = '{4, 4, 4, 4, 5};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn [N];
    logic       load [N];
    logic       ce   [N];
    logic       up   [N];
    logic [4:0] d    [N];
    logic       cout [N];
    logic       done [N];
    logic [3:0] o0, o1, o2, o3;
    logic [4:0] o4;

    counter_mod #(.WIDTH(4), .MAX(64'd15), .MODE(0), .INIT(64'd0)) u0 (
        .clk(clk), .resetn(rstn[0]), .ce(ce[0]), .up(up[0]), .load(load[0]),
        .d(d[0][3:0]), .o(o0), .cout(cout[0]), .done(done[0]));
    counter_mod #(.WIDTH(4), .MAX(64'd9), .MODE(0), .INIT(64'd0)) u1 (
        .clk(clk), .resetn(rstn[1]), .ce(ce[1]), .up(up[1]), .load(load[1]),
        .d(d[1][3:0]), .o(o1), .cout(cout[1]), .done(done[1]));
    counter_mod #(.WIDTH(4), .MAX(64'd5), .MODE(1), .INIT(64'd0)) u2 (
        .clk(clk), .resetn(rstn[2]), .ce(ce[2]), .up(up[2]), .load(load[2]),
        .d(d[2][3:0]), .o(o2), .cout(cout[2]), .done(done[2]));
    counter_mod #(.WIDTH(4), .MAX(64'd3), .MODE(2), .INIT(64'd0)) u3 (
        .clk(clk), .resetn(rstn[3]), .ce(ce[3]), .up(up[3]), .load(load[3]),
        .d(d[3][3:0]), .o(o3), .cout(cout[3]), .done(done[3]));
    counter_mod #(.WIDTH(5), .MAX(64'd20), .MODE(2), .INIT(64'd2)) u4 (
        .clk(clk), .resetn(rstn[4]), .ce(ce[4]), .up(up[4]), .load(load[4]),
        .d(d[4]), .o(o4), .cout(cout[4]), .done(done[4]));

    int checks   = 0;
    int failures = 0;

    // Reference model state: count value, one-shot completion, and whether a reset has been seen.
    int m_o     [N];
    bit m_done  [N];
    bit m_valid [N];

    function automatic logic [63:0] obs_o(input int i);
        case (i)
            0:       return {60'd0, o0};
            1:       return {60'd0, o1};
            2:       return {60'd0, o2};
            3:       return {60'd0, o3};
            default: return {59'd0, o4};
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_model(input int i);
        bit term;
        bit exp_cout;
        if (m_valid[i]) begin
            term     = up[i] ? (m_o[i] == P_MAX[i]) : (m_o[i] == 0);
            exp_cout = ce[i] && !load[i] && term && (P_MODE[i] != 2 || !m_done[i]);
            check($sformatf("u%0d.o", i), obs_o(i), 64'(m_o[i]));
            check($sformatf("u%0d.done", i), {63'd0, done[i]}, {63'd0, m_done[i]});
            check($sformatf("u%0d.cout", i), {63'd0, cout[i]}, {63'd0, exp_cout});
        end
    endtask

    task automatic model_step(input int i);
        int dv;
        dv = (P_W[i] == 4) ? int'(d[i][3:0]) : int'(d[i]);
        if (!rstn[i]) begin
            m_o[i]     = P_INIT[i];
            m_done[i]  = 1'b0;
            m_valid[i] = 1'b1;
        end else if (!m_valid[i]) begin
            m_o[i] = m_o[i];
        end else if (load[i]) begin
            m_o[i]    = (dv > P_MAX[i]) ? P_MAX[i] : dv;
            m_done[i] = 1'b0;
        end else if (ce[i]) begin
            if (P_MODE[i] == 2 && m_done[i]) begin
                m_o[i] = m_o[i];
            end else if (up[i]) begin
                if (m_o[i] < P_MAX[i])   m_o[i] = m_o[i] + 1;
                else if (P_MODE[i] == 0) m_o[i] = 0;
                else if (P_MODE[i] == 2) m_done[i] = 1'b1;
            end else begin
                if (m_o[i] > 0)          m_o[i] = m_o[i] - 1;
                else if (P_MODE[i] == 0) m_o[i] = P_MAX[i];
                else if (P_MODE[i] == 2) m_done[i] = 1'b1;
            end
        end
    endtask

    // One clock: compare all instances mid-cycle, then advance the model on the edge.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < N; i++) check_model(i);
        @(posedge clk);
        for (int i = 0; i < N; i++) model_step(i);
        #1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            m_o[i] = 0; m_done[i] = 1'b0; m_valid[i] = 1'b0;
            rstn[i] = 1'b0; load[i] = 1'b1; ce[i] = 1'b1; up[i] = 1'b1; d[i] = 5'd14;
        end

        // Reset overrides a simultaneous load and count enable.
        tick();
        check("reset_init_u4", {59'd0, o4}, 64'd2);
        check("reset_o_u0", {60'd0, o0}, 64'd0);
        for (int i = 0; i < N; i++) check($sformatf("reset_done_u%0d", i), {63'd0, done[i]}, 64'd0);

        // Free-running counting on every instance.
        for (int i = 0; i < N; i++) begin
            rstn[i] = 1'b1; load[i] = 1'b0; ce[i] = 1'b1; up[i] = 1'b1;
        end
        up[1] = 1'b0;
        for (int k = 0; k < 17; k++) begin
            tick();
            check("wrap_up_o", {60'd0, o0}, 64'((k + 1) % 16));
            check("wrap_up_cout", {63'd0, cout[0]}, {63'd0, ((k + 1) % 16) == 15});
            check("wrap_down_o", {60'd0, o1}, 64'((10 - ((k + 1) % 10)) % 10));
            check("wrap_down_le_max", {63'd0, o1 <= 4'd9}, 64'd1);
            check("sat_o", {60'd0, o2}, 64'((k + 1 < 5) ? k + 1 : 5));
            check("oneshot_o", {60'd0, o3}, 64'((k + 1 < 3) ? k + 1 : 3));
            check("oneshot_done", {63'd0, done[3]}, {63'd0, (k + 1) >= 4});
            if (k == 0) check("post_reset_first_step", {59'd0, o4}, 64'd3);
            if (k >= 5) check("sat_cout", {63'd0, cout[2]}, 64'd1);
        end

        // Saturated counter steps away immediately on a direction change.
        up[2] = 1'b0;
        tick();
        check("sat_step_away", {60'd0, o2}, 64'd4);

        // One-shot in DONE ignores CE and UP.
        for (int j = 0; j < 4; j++) begin
            ce[3] = j[0];
            up[3] = 1'($urandom_range(0, 1));
            tick();
            check("oneshot_hold_o", {60'd0, o3}, 64'd3);
            check("oneshot_hold_done", {63'd0, done[3]}, 64'd1);
        end
        load[3] = 1'b1; d[3] = 5'd1; ce[3] = 1'b1;
        tick();
        check("oneshot_load_o", {60'd0, o3}, 64'd1);
        check("oneshot_load_done", {63'd0, done[3]}, 64'd0);
        load[3] = 1'b0; up[3] = 1'b1;
        tick();
        check("oneshot_resume", {60'd0, o3}, 64'd2);

        // Clamped load; the strobe is suppressed during the load cycle.
        load[1] = 1'b1; d[1] = 5'd14; ce[1] = 1'b1; up[1] = 1'b0;
        #1;
        check("load_cout_low", {63'd0, cout[1]}, 64'd0);
        tick();
        check("load_clamp", {60'd0, o1}, 64'd9);
        load[1] = 1'b0;

        // Reset while in DONE leaves no residual state.
        tick();
        tick();
        check("oneshot_done_again", {63'd0, done[3]}, 64'd1);
        rstn[3] = 1'b0; load[3] = 1'b1; d[3] = 5'd3;
        tick();
        check("reset_in_done_o", {60'd0, o3}, 64'd0);
        check("reset_in_done_done", {63'd0, done[3]}, 64'd0);
        rstn[3] = 1'b1; load[3] = 1'b0;
        tick();
        check("reset_in_done_resume", {60'd0, o3}, 64'd1);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < N; i++) begin
                rstn[i] = ($urandom_range(0, 39) != 0);
                load[i] = ($urandom_range(0, 7) == 0);
                ce[i]   = ($urandom_range(0, 3) != 0);
                up[i]   = 1'($urandom_range(0, 1));
                d[i]    = 5'($urandom_range(0, 31));
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
